// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, fixed-latency RAM between the instruction-fetch
// stage (IF) and the MEM stage. Each access runs IDLE -> ISSUE -> WAIT -> DONE.
// MEM wins grants in IDLE unless IF has lost two contested grants in a row.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr/flush      fetch request, address and fetch flush
//   if_rdata/if_valid         fetched word and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb       load/store request and attributes
//   mem_rdata/mem_valid       load data and one-cycle completion pulse
//   stall                     memory-induced pipeline stall
//   ram_en/we/addr/wdata/wstrb registered RAM command, ram_rdata RAM read data
//
// Optional feature: define MEM_PORT_ARB_STATS_EN to add the saturating
// stat_if_grants / stat_mem_grants / stat_conflicts counters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  flush,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_valid,
  output logic                  stall,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W/8-1:0]   ram_wstrb,
`ifdef MEM_PORT_ARB_STATS_EN
  output logic [31:0]           stat_if_grants,
  output logic [31:0]           stat_mem_grants,
  output logic [31:0]           stat_conflicts,
`endif
  input  logic [DATA_W-1:0]     ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_END = 4'(MEM_LAT);

  state_t      state, state_next;
  logic        owner_mem;   // 1: current transaction belongs to MEM
  logic        owner_we;
  logic        drop;        // fetch flushed while in flight
  logic [1:0]  if_wait;     // contested MEM grants since IF last won
  logic [3:0]  lat_cnt;
  logic        if_ok, contested, grant_mem, grant_if, last_wait;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    if_ok      = if_req && !flush;
    contested  = mem_req && if_ok;
    last_wait  = (lat_cnt == LAT_END);
    grant_mem  = 1'b0;
    grant_if   = 1'b0;
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (contested && if_wait == 2'd2) grant_if  = 1'b1;
        else if (mem_req)                 grant_mem = 1'b1;
        else if (if_ok)                   grant_if  = 1'b1;
        if (grant_mem || grant_if) state_next = S_ISSUE;
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (last_wait) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_mem <= 1'b0;
      owner_we  <= 1'b0;
      drop      <= 1'b0;
      if_wait   <= '0;
      lat_cnt   <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      mem_rdata <= '0;
      mem_valid <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wstrb <= '0;
    end else begin
      ram_en    <= 1'b0;
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (grant_mem) begin
            owner_mem <= 1'b1;
            owner_we  <= mem_we;
            ram_en    <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            ram_wstrb <= mem_wstrb;
            if (if_req && if_wait != 2'd2) if_wait <= if_wait + 2'd1;
          end else if (grant_if) begin
            owner_mem <= 1'b0;
            owner_we  <= 1'b0;
            ram_en    <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
            ram_wstrb <= '0;
            if_wait   <= '0;
          end
        end
        S_ISSUE: begin
          lat_cnt <= 4'd1;
          if (!owner_mem && flush) drop <= 1'b1;
        end
        S_WAIT: begin
          if (!last_wait) lat_cnt <= lat_cnt + 4'd1;
          if (!owner_mem && flush) drop <= 1'b1;
          // Valid is registered here so it appears exactly in the DONE cycle;
          // a flush arriving in this same cycle must already suppress it.
          if (last_wait) begin
            if (owner_mem) begin
              mem_valid <= 1'b1;
              if (!owner_we) mem_rdata <= ram_rdata;
            end else if (!(drop || flush)) begin
              if_valid <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end
        end
        S_DONE: drop <= 1'b0;
        default: drop <= 1'b0;
      endcase
    end
  end

  assign stall = (mem_req && !mem_valid) || (if_req && !if_valid && !flush);

`ifdef MEM_PORT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_grants  <= '0;
      stat_mem_grants <= '0;
      stat_conflicts  <= '0;
    end else begin
      if (grant_if && stat_if_grants != '1)
        stat_if_grants <= stat_if_grants + 32'd1;
      if (grant_mem && stat_mem_grants != '1)
        stat_mem_grants <= stat_mem_grants + 32'd1;
      if (state == S_IDLE && mem_req && if_req && stat_conflicts != '1)
        stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule
